// File: rtl/mmcm_lock_sequencer.sv
// MMCM lock sequencer: issues the MMCM reset pulse, waits for lock with a
// bounded number of retries, qualifies lock stability and re-sequences on
// lock loss. Runs entirely in the free-running board clock domain.
module mmcm_lock_sequencer #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 20000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3,
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_mmcm_locked,
   input  logic               i_restart,
   output logic               o_mmcm_reset,
   output logic               o_clk_ready,
   output logic               o_fail,
   output logic               o_lock_lost,
   output logic [RETRY_W-1:0] o_retry_cnt,
   output logic [2:0]         o_state
);

   localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CD = (LOCK_STABLE_CYCLES > MAX_RETRIES) ?
                           LOCK_STABLE_CYCLES : MAX_RETRIES;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P + 1) : 1;

   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_RST_PULSE = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry;
   logic               lock_lost;
   logic               sync_1;
   logic               locked_s;
   logic               retry_inc;
   logic               retry_clr;
   logic               lock_drop;
   logic               cnt_clr;

   // Two-flop synchronizer for the asynchronous MMCM locked status
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_1   <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync_1   <= i_mmcm_locked;
         locked_s <= sync_1;
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_RST_PULSE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; restart overrides every other transition
   always_comb begin
      state_next = state;
      retry_inc  = 1'b0;
      retry_clr  = 1'b0;
      lock_drop  = 1'b0;
      if (i_restart) begin
         state_next = ST_RST_PULSE;
      end else begin
         case (state)
            ST_RST_PULSE: begin
               if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               // a lock seen on the timeout cycle still counts as success
               if (locked_s) begin
                  state_next = ST_STABLE;
               end else if (cnt == TO_LAST) begin
                  if (retry == RETRY_MAX) begin
                     state_next = ST_FAIL;
                  end else begin
                     retry_inc  = 1'b1;
                     state_next = ST_RST_PULSE;
                  end
               end
            end
            ST_STABLE: begin
               if (!locked_s) begin
                  state_next = ST_WAIT_LOCK;
               end else if (cnt == STB_LAST) begin
                  retry_clr  = 1'b1;
                  state_next = ST_RUN;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  lock_drop  = 1'b1;
                  state_next = ST_RST_PULSE;
               end
            end
            ST_FAIL: begin
               state_next = ST_FAIL;
            end
            default: begin
               state_next = ST_RST_PULSE;
            end
         endcase
      end
   end

   assign cnt_clr = i_restart || (state_next != state);

   // Shared phase counter: clears on any transition or restart
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Retry counter and sticky lock-lost flag
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         retry     <= '0;
         lock_lost <= 1'b0;
      end else if (i_restart) begin
         retry     <= '0;
         lock_lost <= 1'b0;
      end else begin
         if (retry_inc) begin
            retry <= retry + 1'b1;
         end else if (retry_clr) begin
            retry <= '0;
         end
         if (lock_drop) lock_lost <= 1'b1;
      end
   end

   // Moore output decode from the registered state
   always_comb begin
      o_mmcm_reset = 1'b0;
      o_clk_ready  = 1'b0;
      o_fail       = 1'b0;
      case (state)
         ST_RST_PULSE: o_mmcm_reset = 1'b1;
         ST_FAIL: begin
            o_mmcm_reset = 1'b1;
            o_fail       = 1'b1;
         end
         ST_RUN:       o_clk_ready  = 1'b1;
         default: begin
            o_mmcm_reset = 1'b0;
         end
      endcase
      o_state     = state;
      o_retry_cnt = retry;
      o_lock_lost = lock_lost;
   end

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Self-checking bench for mmcm_lock_sequencer: directed scenarios plus a
// randomized lock waveform run, compared against a phase/elapsed-time model.
module tb_mmcm_lock_sequencer;

   localparam int RST_P = 4;
   localparam int TO    = 32;
   localparam int STB   = 8;
   localparam int MAXR  = 2;

   localparam logic [8:0] RESET_VEC = 9'b000_1_0_0_0_00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pin = 1'b0;
   logic       restart = 1'b0;
   logic       mmcm_reset;
   logic       clk_ready;
   logic       fail;
   logic       lock_lost;
   logic [1:0] retry_cnt;
   logic [2:0] state;
   logic [8:0] obs;

   int checks   = 0;
   int failures = 0;

   // model: phase number, cycles spent in phase, retries, sticky flag
   int m_phase;
   int m_elapsed;
   int m_retry;
   bit m_lost;
   bit sync_q[$];

   always #5 clk = ~clk;

   assign obs = {state, mmcm_reset, clk_ready, fail, lock_lost, retry_cnt};

   mmcm_lock_sequencer #(
      .RST_PULSE_CYCLES   (RST_P),
      .LOCK_TIMEOUT_CYCLES(TO),
      .LOCK_STABLE_CYCLES (STB),
      .MAX_RETRIES        (MAXR)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_mmcm_locked(pin),
      .i_restart    (restart),
      .o_mmcm_reset (mmcm_reset),
      .o_clk_ready  (clk_ready),
      .o_fail       (fail),
      .o_lock_lost  (lock_lost),
      .o_retry_cnt  (retry_cnt),
      .o_state      (state)
   );

   function automatic logic [8:0] expv();
      logic [2:0] ph;
      logic [1:0] rc;
      ph = 3'(m_phase);
      rc = 2'(m_retry);
      return {ph, (m_phase == 0 || m_phase == 4), (m_phase == 3),
              (m_phase == 4), m_lost, rc};
   endfunction

   task automatic model_reset();
      m_phase   = 0;
      m_elapsed = 0;
      m_retry   = 0;
      m_lost    = 1'b0;
      sync_q.delete();
   endtask

   // one clock edge of the behavioural model, p/r are pre-edge inputs
   task automatic model_step(input bit p, input bit r);
      bit ls;
      ls = (sync_q.size() >= 2) ? sync_q[sync_q.size() - 2] : 1'b0;
      sync_q.push_back(p);
      while (sync_q.size() > 2) void'(sync_q.pop_front());
      if (r) begin
         m_phase = 0; m_elapsed = 0; m_retry = 0; m_lost = 1'b0;
      end else begin
         case (m_phase)
            0: if (m_elapsed + 1 == RST_P) begin m_phase = 1; m_elapsed = 0; end
               else m_elapsed++;
            1: if (ls) begin m_phase = 2; m_elapsed = 0; end
               else if (m_elapsed + 1 == TO) begin
                  m_elapsed = 0;
                  if (m_retry == MAXR) m_phase = 4;
                  else begin m_retry++; m_phase = 0; end
               end else m_elapsed++;
            2: if (!ls) begin m_phase = 1; m_elapsed = 0; end
               else if (m_elapsed + 1 == STB) begin
                  m_phase = 3; m_elapsed = 0; m_retry = 0;
               end else m_elapsed++;
            3: if (!ls) begin m_phase = 0; m_elapsed = 0; m_lost = 1'b1; end
               else m_elapsed++;
            default: m_elapsed++;
         endcase
      end
   endtask

   task automatic tick();
      bit p;
      bit r;
      p = pin;
      r = restart;
      @(posedge clk);
      #1;
      model_step(p, r);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      pin = 1'b0;
      restart = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== RESET_VEC) begin
         failures++;
         $display("FAIL reset_state got=%b exp=%b", obs, RESET_VEC);
      end
   endtask

   task automatic test_lock_first_try();
      int n;
      pin = 1'b0;
      apply_reset();
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (obs !== expv()) begin
            failures++;
            $display("FAIL first_try_model cyc=%0d got=%b exp=%b", i, obs, expv());
         end
         if (i == 3 || i == 4) begin
            checks++;
            if (mmcm_reset !== (i == 3)) begin
               failures++;
               $display("FAIL pulse_len cyc=%0d got=%b exp=%b", i, mmcm_reset, (i == 3));
            end
         end
      end
      pin = 1'b1;
      n = 0;
      while (state !== 3'd2 && n < 20) begin
         tick(); n++;
         checks++;
         if (obs !== expv()) begin
            failures++;
            $display("FAIL first_try_wait got=%b exp=%b", obs, expv());
         end
      end
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL lock_to_stable got=%0d exp=3", n);
      end
      n = 0;
      while (state !== 3'd3 && n < 40) begin tick(); n++; end
      checks++;
      if (n !== STB || clk_ready !== 1'b1 || retry_cnt !== 2'd0) begin
         failures++;
         $display("FAIL stable_to_run got=%0d/%b/%0d exp=%0d/1/0", n, clk_ready, retry_cnt, STB);
      end
   endtask

   task automatic test_retry_fail();
      pin = 1'b0;
      apply_reset();
      for (int i = 1; i <= 3 * (RST_P + TO); i++) begin
         tick();
         checks++;
         if (obs !== expv()) begin
            failures++;
            $display("FAIL retry_model cyc=%0d got=%b exp=%b", i, obs, expv());
         end
         if (i == 3 * (RST_P + TO) - 1) begin
            checks++;
            if (state !== 3'd1 || retry_cnt !== 2'd2) begin
               failures++;
               $display("FAIL pre_fail got=%0d/%0d exp=1/2", state, retry_cnt);
            end
         end
      end
      checks++;
      if (state !== 3'd4 || fail !== 1'b1 || mmcm_reset !== 1'b1) begin
         failures++;
         $display("FAIL fail_entry got=%0d/%b/%b exp=4/1/1", state, fail, mmcm_reset);
      end
      for (int i = 0; i < 20; i++) begin
         pin = 1'($urandom_range(0, 1));
         tick();
      end
      pin = 1'b0;
      repeat (3) tick();
      checks++;
      if (obs !== expv() || fail !== 1'b1) begin
         failures++;
         $display("FAIL fail_sticky got=%b exp=%b", obs, expv());
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (obs !== RESET_VEC) begin
         failures++;
         $display("FAIL fail_restart got=%b exp=%b", obs, RESET_VEC);
      end
      for (int i = 1; i <= RST_P; i++) begin
         tick();
         checks++;
         if (state !== ((i < RST_P) ? 3'd0 : 3'd1)) begin
            failures++;
            $display("FAIL restart_pulse cyc=%0d got=%0d", i, state);
         end
      end
   endtask

   task automatic test_lock_glitch();
      int n;
      bit saw_ready;
      pin = 1'b1;
      apply_reset();
      n = 0;
      while (state !== 3'd2 && n < 40) begin tick(); n++; end
      repeat (4) tick();
      pin = 1'b0;
      repeat (2) tick();
      pin = 1'b1;
      saw_ready = 1'b0;
      n = 0;
      while (state !== 3'd1 && n < 10) begin
         tick(); n++;
         if (clk_ready) saw_ready = 1'b1;
      end
      checks++;
      if (state !== 3'd1 || saw_ready || retry_cnt !== 2'd0) begin
         failures++;
         $display("FAIL glitch_back got=%0d/%b/%0d exp=1/0/0", state, saw_ready, retry_cnt);
      end
      n = 0;
      while (state !== 3'd2 && n < 10) begin tick(); n++; end
      n = 0;
      while (state !== 3'd3 && n < 40) begin
         tick(); n++;
         checks++;
         if (obs !== expv()) begin
            failures++;
            $display("FAIL glitch_model got=%b exp=%b", obs, expv());
         end
      end
      checks++;
      if (n !== STB) begin
         failures++;
         $display("FAIL glitch_requalify got=%0d exp=%0d", n, STB);
      end
   endtask

   task automatic test_lock_loss();
      int n;
      int pulses;
      pin = 1'b1;
      apply_reset();
      n = 0;
      while (state !== 3'd3 && n < 60) begin tick(); n++; end
      pin = 1'b0;
      n = 0;
      while (clk_ready !== 1'b0 && n < 10) begin tick(); n++; end
      checks++;
      if (n !== 3 || lock_lost !== 1'b1 || state !== 3'd0) begin
         failures++;
         $display("FAIL loss_latency got=%0d/%b/%0d exp=3/1/0", n, lock_lost, state);
      end
      pulses = 1;
      n = 0;
      while (state === 3'd0 && n < 20) begin
         tick(); n++;
         if (state === 3'd0) pulses++;
      end
      checks++;
      if (pulses !== RST_P) begin
         failures++;
         $display("FAIL loss_pulse got=%0d exp=%0d", pulses, RST_P);
      end
      pin = 1'b1;
      n = 0;
      while (state !== 3'd3 && n < 60) begin
         tick(); n++;
         checks++;
         if (obs !== expv()) begin
            failures++;
            $display("FAIL relock_model got=%b exp=%b", obs, expv());
         end
      end
      checks++;
      if (state !== 3'd3 || lock_lost !== 1'b1) begin
         failures++;
         $display("FAIL lost_sticky got=%0d/%b exp=3/1", state, lock_lost);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (lock_lost !== 1'b0 || state !== 3'd0) begin
         failures++;
         $display("FAIL lost_clear got=%b/%0d exp=0/0", lock_lost, state);
      end
   endtask

   task automatic test_retry_then_lock();
      int n;
      // attempt 2 waits from edge 40; lock sampled at edge 70 lands on its last cycle
      pin = 1'b0;
      apply_reset();
      repeat (69) tick();
      pin = 1'b1;
      repeat (3) tick();
      checks++;
      if (state !== 3'd2 || retry_cnt !== 2'd1) begin
         failures++;
         $display("FAIL timeout_edge_lock got=%0d/%0d exp=2/1", state, retry_cnt);
      end
      n = 0;
      while (state !== 3'd3 && n < 20) begin
         tick(); n++;
         checks++;
         if (obs !== expv()) begin
            failures++;
            $display("FAIL retry_lock_model got=%b exp=%b", obs, expv());
         end
      end
      checks++;
      if (state !== 3'd3 || retry_cnt !== 2'd0) begin
         failures++;
         $display("FAIL retry_clear_on_run got=%0d/%0d exp=3/0", state, retry_cnt);
      end
      pin = 1'b0;
      apply_reset();
      repeat (70) tick();
      pin = 1'b1;
      repeat (2) tick();
      checks++;
      if (state !== 3'd0 || retry_cnt !== 2'd2) begin
         failures++;
         $display("FAIL late_lock_retry got=%0d/%0d exp=0/2", state, retry_cnt);
      end
   endtask

   task automatic test_async_and_restart();
      int n;
      pin = 1'b1;
      apply_reset();
      n = 0;
      while (state !== 3'd2 && n < 40) begin tick(); n++; end
      repeat (2) tick();
      rst_n = 1'b0;
      #2;
      checks++;
      if (obs !== RESET_VEC) begin
         failures++;
         $display("FAIL async_reset got=%b exp=%b", obs, RESET_VEC);
      end
      apply_reset();
      n = 0;
      while (state !== 3'd3 && n < 60) begin tick(); n++; end
      pin = 1'b0;
      repeat (2) tick();
      checks++;
      if (clk_ready !== 1'b1) begin
         failures++;
         $display("FAIL pre_restart_ready got=%b exp=1", clk_ready);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (obs !== RESET_VEC || obs !== expv()) begin
         failures++;
         $display("FAIL restart_wins got=%b exp=%b", obs, RESET_VEC);
      end
   endtask

   task automatic test_random();
      int len;
      bit lvl;
      pin = 1'b0;
      apply_reset();
      for (int seg = 0; seg < 150; seg++) begin
         if ($urandom_range(0, 39) == 0) apply_reset();
         lvl = 1'($urandom_range(0, 2) != 0);
         len = $urandom_range(1, 50);
         pin = lvl;
         for (int i = 0; i < len; i++) begin
            restart = ($urandom_range(0, 149) == 0);
            tick();
            restart = 1'b0;
            checks++;
            if (obs !== expv()) begin
               failures++;
               $display("FAIL random seg=%0d got=%b exp=%b", seg, obs, expv());
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock_first_try();
      test_retry_fail();
      test_lock_glitch();
      test_lock_loss();
      test_retry_then_lock();
      test_async_and_restart();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmcm_lock_sequencer.md
Name: mmcm_lock_sequencer

Overview:
Sequences the MMCM clock generator from the free-running board clock domain. It issues the MMCM reset pulse and waits for lock with a timeout, retrying a bounded number of times. It qualifies lock stability before declaring the generated clock usable and re-sequences on lock loss. Its outputs drive the clock generator's reset input and gate the downstream AES-GCM reset-release logic.

Parameters:
RST_PULSE_CYCLES, 16, cycles o_mmcm_reset is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 20000, cycles allowed in WAIT_LOCK before an attempt is declared failed (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before RUN (>=1)
MAX_RETRIES, 3, retries after the first attempt before FAIL (>=0)

Ports:
i_clk  input  1  free-running board reference clock (same clock feeding the MMCM input)
i_reset_n  input  1  asynchronous active-low reset
i_mmcm_locked  input  1  MMCM locked status, asynchronous to i_clk
i_restart  input  1  synchronous single-cycle request to restart the full sequence
o_mmcm_reset  output  1  active-high reset to the clock generator
o_clk_ready  output  1  generated clock locked and stable
o_fail  output  1  retries exhausted; sticky until i_restart
o_lock_lost  output  1  sticky: lock dropped while in RUN
o_retry_cnt  output  $clog2(MAX_RETRIES+1) max 1  retries consumed in the current sequence
o_state  output  3  current state encoding

Behaviour:
- Reset: the one clock is i_clk; i_reset_n is asynchronous and active-low. While i_reset_n=0: state=RST_PULSE(0), counter=0, retry_cnt=0, sync FFs=0, o_mmcm_reset=1, o_clk_ready=0, o_fail=0, o_lock_lost=0, o_state=0.
- Lock synchronizer: 2-FF chain on i_mmcm_locked produces locked_s, 2-cycle latency. Only locked_s is used internally.
- Outputs are Moore-decoded from registered state, except the sticky flags. o_mmcm_reset=1 in RST_PULSE and FAIL. o_clk_ready=1 only in RUN. o_fail=1 only in FAIL.
- Counter: single shared counter, width fits max(parameters). It clears on every state transition and increments each cycle otherwise.
- RST_PULSE(0): after exactly RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK(1): if locked_s=1, go to STABLE. Otherwise, when counter = LOCK_TIMEOUT_CYCLES-1:
  - If retry_cnt = MAX_RETRIES, go to FAIL.
  - Else increment retry_cnt and go to RST_PULSE.
  - Lock seen on the timeout cycle wins, i.e. go to STABLE.
- STABLE(2): if locked_s=0, go to WAIT_LOCK with a fresh timeout and no retry consumed. When counter = LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN and clear retry_cnt.
- RUN(3): if locked_s=0, set o_lock_lost and go to RST_PULSE. retry_cnt stays 0, so a full retry budget is available.
- FAIL(4): remain in FAIL indefinitely. i_mmcm_locked is ignored.
- i_restart=1 in any state has highest priority over every other transition:
  - Next state RST_PULSE, counter=0, retry_cnt=0.
  - Clears o_lock_lost; o_fail drops via state.
  - Restart in RST_PULSE restarts the pulse count, lengthening the pulse.
- Timing:
  - Lock edge at the i_mmcm_locked pin to STABLE entry: 3 cycles.
  - STABLE to RUN: LOCK_STABLE_CYCLES cycles.
  - Lock loss at the pin in RUN to o_clk_ready=0: 3 cycles.
- Encodings 5-7 are unreachable and decode to RST_PULSE on the next cycle.
- Reset asserted mid-sequence returns immediately to the reset values above.

Test Plan:
Use params RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release reset, raise i_mmcm_locked 10 cycles after reset release and hold it -> o_mmcm_reset high exactly 4 cycles; STABLE entered 3 cycles after the lock edge; o_clk_ready=1 eight cycles later; o_retry_cnt=0.
2. i_mmcm_locked held 0 -> RST_PULSE/WAIT_LOCK cycle repeats with o_retry_cnt 0->1->2, then FAIL. o_fail=1 and o_mmcm_reset=1 at cycle 3*(4+32) after reset release and held. Then pulse i_restart -> o_fail=0, o_retry_cnt=0, new 4-cycle reset pulse.
3. Lock glitch low for 2 cycles at STABLE cycle 5 -> return to WAIT_LOCK, o_clk_ready stays 0, o_retry_cnt unchanged. When the lock returns, the full 8-cycle qualification restarts.
4. In RUN, drop i_mmcm_locked -> o_clk_ready=0 three cycles later; o_lock_lost=1 sticky; 4-cycle o_mmcm_reset pulse. Relock -> RUN with o_lock_lost still 1 until i_restart.
5. Fail attempt 1 by timeout, lock on attempt 2 -> o_retry_cnt=1 in WAIT_LOCK/STABLE, cleared to 0 on RUN entry. Also cover lock arriving exactly on counter=31 -> goes to STABLE, not retry.
6. Assert i_reset_n=0 while in STABLE, and separately i_restart coincident with a locked_s fall in RUN -> all outputs return to reset values asynchronously. The restart case goes to RST_PULSE with o_lock_lost=0, because restart wins.
